// File: rtl/bsg_manycore_loader_credit_buffer.sv
// Generic registered FIFO. Data becomes visible one cycle after the write, with no bypass path.
// Latency: 1 cycle from enq_i to the head on data_o.
// Backpressure: full_o and empty_o come from state only. The caller must gate enq_i and deq_i with them.
module bsg_manycore_loader_fifo #(
    parameter int width_p = 80,
    parameter int els_p   = 4
) (
    input  logic               clk_i,
    input  logic               reset_n_i,
    input  logic [width_p-1:0] data_i,
    input  logic               enq_i,
    input  logic               deq_i,
    output logic [width_p-1:0] data_o,
    output logic               full_o,
    output logic               empty_o
);
    localparam int idx_w_lp = $clog2(els_p);
    localparam logic [idx_w_lp:0] ptr_one_lp = (idx_w_lp+1)'(1);

    logic [width_p-1:0] mem_r [els_p];
    logic [idx_w_lp:0]  wr_ptr_r;
    logic [idx_w_lp:0]  rd_ptr_r;

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            wr_ptr_r <= '0;
            rd_ptr_r <= '0;
        end else begin
            if (enq_i) wr_ptr_r <= wr_ptr_r + ptr_one_lp;
            if (deq_i) rd_ptr_r <= rd_ptr_r + ptr_one_lp;
        end
    end

    // Storage is not reset: the pointers alone determine which entries are valid
    always_ff @(posedge clk_i) begin
        if (enq_i) mem_r[wr_ptr_r[idx_w_lp-1:0]] <= data_i;
    end

    assign data_o  = mem_r[rd_ptr_r[idx_w_lp-1:0]];
    assign empty_o = (wr_ptr_r == rd_ptr_r);
    assign full_o  = (wr_ptr_r[idx_w_lp] != rd_ptr_r[idx_w_lp]) &&
                     (wr_ptr_r[idx_w_lp-1:0] == rd_ptr_r[idx_w_lp-1:0]);
endmodule

// Credit-gated loader packet buffer with outstanding-request fence (drain, then wait for all credits).
// Latency: 1 cycle from an accepted data_i until it can appear on data_o.
// Backpressure: ready_o drops when the FIFO is full or a fence is in progress. v_o requires a credit.
module bsg_manycore_loader_credit_buffer #(
    parameter int packet_width_p    = 80,
    parameter int els_p             = 4,
    parameter int max_out_credits_p = 128
) (
    input  logic                                     clk_i,
    input  logic                                     reset_n_i,
    input  logic [packet_width_p-1:0]                data_i,
    input  logic                                     v_i,
    output logic                                     ready_o,
    output logic [packet_width_p-1:0]                data_o,
    output logic                                     v_o,
    input  logic                                     ready_i,
    input  logic                                     credit_return_i,
    input  logic                                     fence_i,
    output logic                                     fence_done_o,
    output logic [$clog2(max_out_credits_p+1)-1:0]   out_credits_o,
    output logic                                     drained_o,
    output logic                                     credit_err_o
);
    localparam int cred_w_lp = $clog2(max_out_credits_p+1);
    localparam logic [cred_w_lp-1:0] max_cred_lp = cred_w_lp'(max_out_credits_p);
    localparam logic [cred_w_lp-1:0] cred_one_lp = cred_w_lp'(1);

    typedef enum logic [1:0] {
        RUN       = 2'd0,
        DRAIN     = 2'd1,
        WAIT_CRED = 2'd2
    } state_e;

    state_e               state_r, state_n;
    logic [cred_w_lp-1:0] credits_r, credits_n;
    logic                 credit_err_r, err_set;
    logic                 fifo_full, fifo_empty;
    logic                 enq, send, credits_full;

    bsg_manycore_loader_fifo #(
        .width_p (packet_width_p),
        .els_p   (els_p)
    ) fifo (
        .clk_i     (clk_i),
        .reset_n_i (reset_n_i),
        .data_i    (data_i),
        .enq_i     (enq),
        .deq_i     (send),
        .data_o    (data_o),
        .full_o    (fifo_full),
        .empty_o   (fifo_empty)
    );

    assign credits_full  = (credits_r == max_cred_lp);
    assign ready_o       = ~fifo_full & (state_r == RUN);
    assign enq           = v_i & ready_o;
    assign v_o           = ~fifo_empty & (credits_r != '0) & (state_r != WAIT_CRED);
    assign send          = v_o & ready_i;
    assign out_credits_o = credits_r;
    assign drained_o     = fifo_empty & credits_full;
    assign credit_err_o  = credit_err_r;

    // A send and a return in the same cycle cancel. A return into a full counter is an error.
    always_comb begin
        credits_n = credits_r;
        err_set   = 1'b0;
        if (send && !credit_return_i) begin
            credits_n = credits_r - cred_one_lp;
        end else if (!send && credit_return_i) begin
            if (credits_full) err_set   = 1'b1;
            else              credits_n = credits_r + cred_one_lp;
        end
    end

    always_comb begin
        state_n      = state_r;
        fence_done_o = 1'b0;
        case (state_r)
            RUN:       if (fence_i) state_n = DRAIN;
            DRAIN:     if (fifo_empty) state_n = WAIT_CRED;
            WAIT_CRED: begin
                if (credits_full) begin
                    state_n      = RUN;
                    fence_done_o = 1'b1;
                end
            end
            default:   state_n = RUN;
        endcase
    end

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state_r      <= RUN;
            credits_r    <= max_cred_lp;
            credit_err_r <= 1'b0;
        end else begin
            state_r      <= state_n;
            credits_r    <= credits_n;
            credit_err_r <= credit_err_r | err_set;
        end
    end
endmodule

// File: tb/tb_bsg_manycore_loader_credit_buffer.sv
// Bench for the loader credit buffer: directed scenarios plus random traffic.
// A queue-based reference model is compared against the DUT on every falling edge.
module tb_bsg_manycore_loader_credit_buffer;
    localparam int W   = 80;
    localparam int ELS = 4;
    localparam int MAX = 128;
    localparam int CW  = 8;

    logic          clk_i = 1'b0;
    logic          reset_n_i;
    logic [W-1:0]  data_i;
    logic          v_i;
    logic          ready_o;
    logic [W-1:0]  data_o;
    logic          v_o;
    logic          ready_i;
    logic          credit_return_i;
    logic          fence_i;
    logic          fence_done_o;
    logic [CW-1:0] out_credits_o;
    logic          drained_o;
    logic          credit_err_o;

    bsg_manycore_loader_credit_buffer #(
        .packet_width_p    (W),
        .els_p             (ELS),
        .max_out_credits_p (MAX)
    ) dut (
        .clk_i           (clk_i),
        .reset_n_i       (reset_n_i),
        .data_i          (data_i),
        .v_i             (v_i),
        .ready_o         (ready_o),
        .data_o          (data_o),
        .v_o             (v_o),
        .ready_i         (ready_i),
        .credit_return_i (credit_return_i),
        .fence_i         (fence_i),
        .fence_done_o    (fence_done_o),
        .out_credits_o   (out_credits_o),
        .drained_o       (drained_o),
        .credit_err_o    (credit_err_o)
    );

    always #5 clk_i = ~clk_i;

    int n_vec = 0;
    int n_err = 0;

    // Reference model: packet queue, credit count, sticky error, fence phase (0 idle, 1 draining, 2 waiting)
    logic [W-1:0] m_q[$];
    int           m_cred  = MAX;
    logic         m_err   = 1'b0;
    int           m_phase = 0;

    logic e_rdy, e_v, e_done, e_drn, m_snd, m_psh;

    task automatic chk1(input string name, input logic act, input logic exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
        end
    endtask

    task automatic chk8(input string name, input logic [CW-1:0] act, input logic [CW-1:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic chkd(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [W-1:0] rnd_pkt();
        return {$urandom(), $urandom(), 16'($urandom())};
    endfunction

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    always @(negedge clk_i) begin
        if (!reset_n_i) begin
            m_q.delete();
            m_cred  = MAX;
            m_err   = 1'b0;
            m_phase = 0;
        end
        e_rdy  = (m_q.size() < ELS) && (m_phase == 0);
        e_v    = (m_q.size() > 0) && (m_cred > 0) && (m_phase != 2);
        e_done = (m_phase == 2) && (m_cred == MAX);
        e_drn  = (m_q.size() == 0) && (m_cred == MAX);
        chk1("ready_o", ready_o, e_rdy);
        chk1("v_o", v_o, e_v);
        chk1("fence_done_o", fence_done_o, e_done);
        chk1("drained_o", drained_o, e_drn);
        chk1("credit_err_o", credit_err_o, m_err);
        chk8("out_credits_o", out_credits_o, CW'(m_cred));
        if (e_v) chkd("data_o", data_o, m_q[0]);
        if (reset_n_i) begin
            m_snd = e_v && ready_i;
            m_psh = v_i && e_rdy;
            case (m_phase)
                0:       if (fence_i) m_phase = 1;
                1:       if (m_q.size() == 0) m_phase = 2;
                2:       if (m_cred == MAX) m_phase = 0;
                default: m_phase = 0;
            endcase
            if (m_snd) void'(m_q.pop_front());
            if (m_psh) m_q.push_back(data_i);
            if (m_snd && !credit_return_i) m_cred--;
            else if (!m_snd && credit_return_i) begin
                if (m_cred == MAX) m_err = 1'b1;
                else               m_cred++;
            end
        end
    end

    logic [W-1:0] pkt;
    bit           drained_ok;

    initial begin
        reset_n_i = 1'b0; v_i = 1'b0; ready_i = 1'b0;
        credit_return_i = 1'b0; fence_i = 1'b0; data_i = '0;

        // Reset values
        repeat (3) tick();
        chk1("rst_ready", ready_o, 1'b1);
        chk1("rst_v", v_o, 1'b0);
        chk8("rst_credits", out_credits_o, 8'd128);
        chk1("rst_drained", drained_o, 1'b1);
        chk1("rst_err", credit_err_o, 1'b0);
        tick(); reset_n_i = 1'b1;

        // One packet: no bypass, so it becomes valid on the following cycle
        tick(); v_i = 1'b1; pkt = rnd_pkt(); data_i = pkt;
        #1 chk1("t1_v_cyc0", v_o, 1'b0);
        tick(); v_i = 1'b0;
        #1 chk1("t1_v_cyc1", v_o, 1'b1);
        chkd("t1_data", data_o, pkt);
        ready_i = 1'b1;
        tick(); ready_i = 1'b0;
        #1 chk8("t1_cred_used", out_credits_o, 8'd127);
        credit_return_i = 1'b1;
        tick(); credit_return_i = 1'b0;
        #1 chk8("t1_cred_back", out_credits_o, 8'd128);

        // Backpressure: 5 offered into a 4-deep FIFO
        for (int i = 0; i < 5; i++) begin
            tick(); v_i = 1'b1; data_i = rnd_pkt();
            #1 chk1("t2_ready", ready_o, (i < 4));
        end
        tick(); v_i = 1'b0; ready_i = 1'b1;
        repeat (3) tick();
        tick(); ready_i = 1'b0;
        #1 chk8("t2_cred", out_credits_o, 8'd124);
        chk1("t2_v_empty", v_o, 1'b0);
        credit_return_i = 1'b1;
        repeat (3) tick();
        tick(); credit_return_i = 1'b0;
        #1 chk8("t2_cred_back", out_credits_o, 8'd128);

        // A send and a return in the same cycle cancel, and an overflow return sets the sticky error
        tick(); v_i = 1'b1; data_i = rnd_pkt();
        tick(); v_i = 1'b0; ready_i = 1'b1;
        tick(); ready_i = 1'b0; v_i = 1'b1; data_i = rnd_pkt();
        tick(); v_i = 1'b0;
        #1 chk8("t4_pre", out_credits_o, 8'd127);
        ready_i = 1'b1; credit_return_i = 1'b1;
        tick(); ready_i = 1'b0; credit_return_i = 1'b0;
        #1 chk8("t4_simul", out_credits_o, 8'd127);
        chk1("t4_no_err", credit_err_o, 1'b0);
        credit_return_i = 1'b1;
        tick();
        #1 chk8("t4_full", out_credits_o, 8'd128);
        chk1("t4_err_pre", credit_err_o, 1'b0);
        tick(); credit_return_i = 1'b0;
        #1 chk8("t4_hold", out_credits_o, 8'd128);
        chk1("t4_err", credit_err_o, 1'b1);
        tick();
        #1 chk1("t4_err_sticky", credit_err_o, 1'b1);

        // Credit exhaustion: no returns, so sending stops with packets still queued
        ready_i = 1'b1; v_i = 1'b1;
        for (int i = 0; i < 140; i++) begin
            tick(); data_i = rnd_pkt();
        end
        tick(); v_i = 1'b0;
        #1 chk1("t3_v_stall", v_o, 1'b0);
        chk8("t3_cred0", out_credits_o, 8'd0);
        chk1("t3_full", ready_o, 1'b0);
        credit_return_i = 1'b1;
        #1 chk1("t3_v_ret_cyc", v_o, 1'b0);
        tick(); credit_return_i = 1'b0;
        #1 chk1("t3_v_after_ret", v_o, 1'b1);
        chk8("t3_cred1", out_credits_o, 8'd1);
        tick(); ready_i = 1'b0;
        #1 chk1("t3_v_stall2", v_o, 1'b0);
        chk8("t3_cred0b", out_credits_o, 8'd0);

        // Refill credits while holding the 3 queued packets
        credit_return_i = 1'b1;
        repeat (127) tick();
        tick(); credit_return_i = 1'b0;
        #1 chk8("t5_refill", out_credits_o, 8'd128);
        chk1("t5_v_queued", v_o, 1'b1);

        // Fence: the fence cycle still accepts, then the FIFO drains and waits for all credits
        fence_i = 1'b1; v_i = 1'b1; data_i = rnd_pkt();
        #1 chk1("t5_ready_fence_cyc", ready_o, 1'b1);
        tick(); fence_i = 1'b0; ready_i = 1'b1; data_i = rnd_pkt();
        #1 chk1("t5_ready_drain", ready_o, 1'b0);
        repeat (3) tick();
        tick(); v_i = 1'b0; ready_i = 1'b0;
        #1 chk8("t5_cred_out", out_credits_o, 8'd124);
        chk1("t5_v_drained", v_o, 1'b0);
        for (int k = 0; k < 4; k++) begin
            credit_return_i = 1'b1;
            #1 chk1("t5_done_early", fence_done_o, 1'b0);
            tick(); credit_return_i = 1'b0;
            #1;
            if (k < 3) begin
                chk1("t5_done_gap", fence_done_o, 1'b0);
                tick();
            end
        end
        chk1("t5_done", fence_done_o, 1'b1);
        chk1("t5_ready_wait", ready_o, 1'b0);
        tick();
        #1 chk1("t5_done_once", fence_done_o, 1'b0);
        chk1("t5_ready_run", ready_o, 1'b1);

        // A fence on an idle buffer completes two cycles after the request
        tick(); fence_i = 1'b1;
        #1 chk1("tf_done0", fence_done_o, 1'b0);
        tick(); fence_i = 1'b0;
        #1 chk1("tf_done1", fence_done_o, 1'b0);
        chk1("tf_ready1", ready_o, 1'b0);
        tick();
        #1 chk1("tf_done2", fence_done_o, 1'b1);
        chk1("tf_drained", drained_o, 1'b1);
        tick();
        #1 chk1("tf_done3", fence_done_o, 1'b0);
        chk1("tf_ready3", ready_o, 1'b1);

        // Random traffic against the model
        for (int i = 0; i < 3000; i++) begin
            tick();
            v_i             = ($urandom_range(0, 3) != 0);
            data_i          = rnd_pkt();
            ready_i         = ($urandom_range(0, 3) != 0);
            fence_i         = ($urandom_range(0, 39) == 0);
            credit_return_i = (m_cred < MAX) && ($urandom_range(0, 2) != 0);
        end
        tick(); v_i = 1'b0; fence_i = 1'b0; ready_i = 1'b1;
        drained_ok = 1'b0;
        for (int i = 0; i < 600 && !drained_ok; i++) begin
            credit_return_i = (m_cred < MAX);
            tick();
            drained_ok = (m_q.size() == 0) && (m_cred == MAX) && (m_phase == 0);
        end
        credit_return_i = 1'b0; ready_i = 1'b0;
        n_vec++;
        if (!drained_ok) begin
            n_err++;
            $display("FAIL drain_timeout: buffer did not drain within 600 cycles");
        end

        // Asynchronous reset while waiting for credits
        tick(); v_i = 1'b1; data_i = rnd_pkt();
        tick(); v_i = 1'b0; ready_i = 1'b1;
        tick(); ready_i = 1'b0; fence_i = 1'b1;
        tick(); fence_i = 1'b0;
        tick();
        chk8("t6_cred_wait", out_credits_o, 8'd127);
        chk1("t6_ready_wait", ready_o, 1'b0);
        chk1("t6_done_wait", fence_done_o, 1'b0);
        #2 reset_n_i = 1'b0;
        #1 chk1("t6_ready", ready_o, 1'b1);
        chk1("t6_v", v_o, 1'b0);
        chk8("t6_cred", out_credits_o, 8'd128);
        chk1("t6_drained", drained_o, 1'b1);
        chk1("t6_err", credit_err_o, 1'b0);
        chk1("t6_done", fence_done_o, 1'b0);
        repeat (2) tick();
        reset_n_i = 1'b1;
        repeat (3) tick();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
